// File: rtl/regfile_scoreboard.sv
// Multi-read, dual-write register file with a per-register busy scoreboard.
// Reads are combinational (0 cycles); writes and busy updates take effect at the clock edge; no backpressure.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we0,
  input  logic [AW-1:0]       w_addr0,
  input  logic [XLEN-1:0]     w_data0,
  input  logic                we1,
  input  logic [AW-1:0]       w_addr1,
  input  logic [XLEN-1:0]     w_data1,
  input  logic [NRD*AW-1:0]   r_addr,
  output logic [NRD*XLEN-1:0] r_data,
  output logic [NRD-1:0]      r_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;

  assign wr0_ok = we0 && !((ZERO_REG != 0) && (w_addr0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (w_addr1 == '0));
  assign iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

  // Port 1 is applied after port 0 so it wins on an address collision.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wr0_ok) regs_d[w_addr0] = w_data0;
    if (wr1_ok) regs_d[w_addr1] = w_data1;
  end

  // Writeback clears first, then a new issue sets: the newest producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (we0)    busy_d[w_addr0] = 1'b0;
    if (we1)    busy_d[w_addr1] = 1'b0;
    if (iss_ok) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rd;
  logic            rb;

  // Later assignments override earlier ones, so the lowest-priority source comes first.
  always_comb begin
    r_data = '0;
    r_busy = '0;
    ra     = '0;
    rd     = '0;
    rb     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra = r_addr[i*AW +: AW];
      rd = regs_q[ra];
      rb = busy_q[ra];
      if ((BYPASS != 0) && we0 && (w_addr0 == ra)) begin
        rd = w_data0;
        rb = 1'b0;
      end
      if ((BYPASS != 0) && we1 && (w_addr1 == ra)) begin
        rd = w_data1;
        rb = 1'b0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
      // The bypass path would otherwise leak write data while reset is held.
      if (!rst_n) begin
        rd = '0;
        rb = 1'b0;
      end
      r_data[i*XLEN +: XLEN] = rd;
      r_busy[i]              = rb;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing build and one non-bypassing build share stimulus.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        we0;
  logic [4:0]  w_addr0;
  logic [31:0] w_data0;
  logic        we1;
  logic [4:0]  w_addr1;
  logic [31:0] w_data1;
  logic [9:0]  r_addr;
  logic        issue_valid;
  logic [4:0]  issue_addr;

  logic [63:0] r_data_a;
  logic [1:0]  r_busy_a;
  logic [31:0] busy_vec_a;
  logic [63:0] r_data_b;
  logic [1:0]  r_busy_b;
  logic [31:0] busy_vec_b;

  int checks;
  int errors;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .w_addr0(w_addr0), .w_data0(w_data0),
    .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
    .r_addr(r_addr), .r_data(r_data_a), .r_busy(r_busy_a),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .busy_vec(busy_vec_a)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .w_addr0(w_addr0), .w_data0(w_data0),
    .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
    .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .busy_vec(busy_vec_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; w_addr0 = '0; w_data0 = '0;
    we1 = 0; w_addr1 = '0; w_data1 = '0;
    issue_valid = 0; issue_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    r_addr = {p1, p0};
  endtask

  initial begin
    logic [4:0] av;
    checks = 0;
    errors = 0;
    clk    = 0;
    rst_n  = 0;
    idle();
    set_rd(5'd0, 5'd0);
    #2;

    // Reset held: everything reads zero
    check("rst_bvec_a", busy_vec_a, 0);
    check("rst_bvec_b", busy_vec_b, 0);
    for (int a = 0; a < 32; a++) begin
      av = 5'(a);
      set_rd(av, av);
      #1;
      check("rst_rdata_a", r_data_a, 0);
      check("rst_rbusy_a", r_busy_a, 0);
      check("rst_rdata_b", r_data_b, 0);
    end

    @(negedge clk);
    rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      av = 5'(a);
      set_rd(av, 5'(31 - a));
      #1;
      check("post_rst_rdata_a", r_data_a, 0);
      check("post_rst_rbusy_a", r_busy_a, 0);
      check("post_rst_rdata_b", r_data_b, 0);
    end
    check("post_rst_bvec_a", busy_vec_a, 0);

    // Bypass vs. registered visibility
    @(negedge clk);
    we0 = 1; w_addr0 = 5'd5; w_data0 = 32'hDEADBEEF;
    set_rd(5'd5, 5'd1);
    #1;
    check("byp_same_a", r_data_a[31:0], 32'hDEADBEEF);
    check("byp_same_b", r_data_b[31:0], 32'h0);
    @(posedge clk); #1;
    idle();
    #1;
    check("byp_next_a", r_data_a[31:0], 32'hDEADBEEF);
    check("byp_next_b", r_data_b[31:0], 32'hDEADBEEF);
    check("wr_nonbusy_bvec", busy_vec_a, 0);

    // Dual write collision: port 1 wins
    @(negedge clk);
    we0 = 1; w_addr0 = 5'd7; w_data0 = 32'h11;
    we1 = 1; w_addr1 = 5'd7; w_data1 = 32'h22;
    set_rd(5'd5, 5'd7);
    #1;
    check("coll_same_a", r_data_a[63:32], 32'h22);
    @(posedge clk); #1;
    idle();
    #1;
    check("coll_next_a", r_data_a[63:32], 32'h22);
    check("coll_next_b", r_data_b[63:32], 32'h22);

    // Register 0 ignores writes
    @(negedge clk);
    we0 = 1; w_addr0 = 5'd0; w_data0 = 32'h33;
    set_rd(5'd0, 5'd7);
    #1;
    check("zero_same_a", r_data_a[31:0], 32'h0);
    check("zero_same_b", r_data_b[31:0], 32'h0);
    @(posedge clk); #1;
    idle();
    #1;
    check("zero_next_a", r_data_a[31:0], 32'h0);
    check("zero_next_b", r_data_b[31:0], 32'h0);

    // Issue then writeback clears busy
    @(negedge clk);
    issue_valid = 1; issue_addr = 5'd3;
    set_rd(5'd3, 5'd5);
    #1;
    check("iss_same_rbusy", r_busy_a, 2'b00);
    @(posedge clk); #1;
    idle();
    #1;
    check("iss_next_bvec_a", busy_vec_a, 32'h0000_0008);
    check("iss_next_bvec_b", busy_vec_b, 32'h0000_0008);
    check("iss_next_rbusy_a", r_busy_a, 2'b01);
    check("iss_next_rbusy_b", r_busy_b, 2'b01);
    @(negedge clk);
    we1 = 1; w_addr1 = 5'd3; w_data1 = 32'hABCD;
    #1;
    check("wb_same_rbusy_a", r_busy_a, 2'b00);
    check("wb_same_rdata_a", r_data_a[31:0], 32'hABCD);
    check("wb_same_rbusy_b", r_busy_b, 2'b01);
    @(posedge clk); #1;
    idle();
    #1;
    check("wb_next_bvec_a", busy_vec_a, 0);
    check("wb_next_rdata_b", r_data_b[31:0], 32'hABCD);

    // Issue and writeback to the same register: busy ends set
    @(negedge clk);
    issue_valid = 1; issue_addr = 5'd9;
    we0 = 1; w_addr0 = 5'd9; w_data0 = 32'h99;
    set_rd(5'd9, 5'd3);
    @(posedge clk); #1;
    idle();
    #1;
    check("iss_wb_bvec_a", busy_vec_a, 32'h0000_0200);
    check("iss_wb_rbusy_a", r_busy_a, 2'b01);
    check("iss_wb_rdata_a", r_data_a, {32'hABCD, 32'h99});

    // Issue to register 0 is ignored
    @(negedge clk);
    issue_valid = 1; issue_addr = 5'd0;
    @(posedge clk); #1;
    idle();
    #1;
    check("iss_zero_bvec", busy_vec_a, 32'h0000_0200);

    // Asynchronous reset mid-cycle with state loaded and a write in flight
    @(negedge clk);
    set_rd(5'd5, 5'd7);
    we0 = 1; w_addr0 = 5'd7; w_data0 = 32'h77;
    #1;
    check("pre_arst_rdata_a", r_data_a, {32'h77, 32'hDEADBEEF});
    #1;
    rst_n = 0;
    #1;
    check("arst_bvec_a", busy_vec_a, 0);
    check("arst_rdata_a", r_data_a, 0);
    check("arst_rbusy_a", r_busy_a, 0);
    check("arst_rdata_b", r_data_b, 0);
    @(posedge clk); #1;
    @(negedge clk);
    idle();
    rst_n = 1;
    set_rd(5'd9, 5'd7);
    #1;
    check("arst_drop_wr_a", r_data_a, 0);
    check("arst_drop_bvec", busy_vec_a, 0);
    check("arst_drop_rbusy", r_busy_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
